dmem_store_responder: RTL

//  Responder end of the CPU data-store interface (memwrite/dataadr/writedata) driven by the 16-bit

---
 rtl/dmem_store_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_store_responder.sv
// Data-store responder for the 16-bit single-cycle core: word RAM with combinational read,
// a small MMIO status window, and a store-log FIFO drained over valid/ready.
module dmem_store_responder #(
    parameter int          AW        = 6,
    parameter int          LOG_AW    = 3,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [15:0] dataadr,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        log_valid,
    output logic [15:0] log_addr,
    output logic [15:0] log_data,
    input  logic        log_ready,
    output logic        overflow
);

    localparam int RAM_WORDS = 1 << AW;
    localparam int DEPTH     = 1 << LOG_AW;
    localparam int PW        = LOG_AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    localparam logic [6:0] OFF_ZERO   = 7'h00;
    localparam logic [6:0] OFF_STATUS = 7'h01;
    localparam logic [6:0] OFF_CNT    = 7'h02;
    localparam logic [6:0] OFF_CLEAR  = 7'h03;

    logic [15:0]   mem_r       [0:RAM_WORDS-1];
    logic [15:0]   fifo_addr_r [0:DEPTH-1];
    logic [15:0]   fifo_data_r [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          overflow_r;
    logic [15:0]   store_cnt_r;

    logic          is_mmio_s;
    logic [6:0]    mmio_off_s;
    logic [AW-1:0] ram_idx_s;
    logic [PW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          clear_s;
    logic          drop_s;

    // Address decode and FIFO handshake terms.
    always_comb begin
        is_mmio_s  = (dataadr[15:8] == MMIO_BASE[15:8]);
        mmio_off_s = dataadr[7:1];
        ram_idx_s  = dataadr[AW:1];
        count_s    = wr_ptr_r - rd_ptr_r;
        full_s     = (count_s == DEPTH_C);
        empty_s    = (count_s == {PW{1'b0}});
        pop_s      = !empty_s && log_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
        push_s     = memwrite && (!full_s || pop_s);
        drop_s     = memwrite && full_s && !pop_s;
        clear_s    = memwrite && is_mmio_s && (mmio_off_s == OFF_CLEAR);
    end

    // Load data mux: MMIO registers or RAM word.
    always_comb begin
        readdata = 16'h0000;
        if (is_mmio_s) begin
            case (mmio_off_s)
                OFF_ZERO:   readdata = 16'h0000;
                OFF_STATUS: readdata = {overflow_r, {(15 - PW){1'b0}}, count_s};
                OFF_CNT:    readdata = store_cnt_r;
                default:    readdata = 16'h0000;
            endcase
        end else begin
            readdata = mem_r[ram_idx_s];
        end
    end

    // Head-of-log presentation; zero whenever the log is empty.
    always_comb begin
        log_valid = !empty_s;
        if (empty_s) begin
            log_addr = 16'h0000;
            log_data = 16'h0000;
        end else begin
            log_addr = fifo_addr_r[rd_ptr_r[LOG_AW-1:0]];
            log_data = fifo_data_r[rd_ptr_r[LOG_AW-1:0]];
        end
    end

    assign overflow = overflow_r;

    // Pointers, sticky overflow and store counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            overflow_r  <= 1'b0;
            store_cnt_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            // The clearing store takes precedence over its own count and drop.
            if (clear_s) begin
                overflow_r  <= 1'b0;
                store_cnt_r <= 16'h0000;
            end else if (memwrite) begin
                store_cnt_r <= store_cnt_r + 16'h0001;
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && !is_mmio_s) begin
            mem_r[ram_idx_s] <= writedata;
        end
    end

    // Log storage write port.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            fifo_addr_r[wr_ptr_r[LOG_AW-1:0]] <= dataadr;
            fifo_data_r[wr_ptr_r[LOG_AW-1:0]] <= writedata;
        end
    end

endmodule
